// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with per-byte write enables, registered read data and post-reset zero-fill.
// Latency: 1 cycle from accepted access to data_out_x/valid_x; ready rises 2**ADDR_W cycles after reset release.
// Backpressure: none while ready=1; all accesses are ignored (no write, no valid) while the sweep runs.
module dual_port_ram_be #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int RDW_MODE   = 0,
    parameter int A_PRIORITY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                en_a,
    input  logic                we_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   data_in_a,
    output logic [DATA_W-1:0]   data_out_a,
    output logic                valid_a,
    input  logic                en_b,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   data_in_b,
    output logic [DATA_W-1:0]   data_out_b,
    output logic                valid_b,
    output logic                collision,
    output logic [CNT_W-1:0]    collision_cnt
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] data_out_a_q, data_out_a_d;
    logic [DATA_W-1:0] data_out_b_q, data_out_b_d;
    logic              valid_a_q, valid_a_d;
    logic              valid_b_q, valid_b_d;
    logic              collision_q, collision_d;
    logic [CNT_W-1:0]  collision_cnt_q, collision_cnt_d;

    logic              acc_a, acc_b, wr_a, wr_b, same_addr, conflict, init_we;
    logic [NB-1:0]     wbyte_a, wbyte_b;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b;

    // Access qualification; an access on the reset edge is discarded so nothing leaks past reset.
    always_comb begin
        acc_a     = (state_q == ST_RUN) && en_a && !rst;
        acc_b     = (state_q == ST_RUN) && en_b && !rst;
        wr_a      = acc_a && we_a;
        wr_b      = acc_b && we_b;
        wbyte_a   = be_a & {NB{wr_a}};
        wbyte_b   = be_b & {NB{wr_b}};
        same_addr = (addr_a == addr_b);
        conflict  = acc_a && acc_b && same_addr && (we_a || we_b);
        init_we   = (state_q == ST_INIT) && !rst;
        old_a     = mem[addr_a];
        old_b     = mem[addr_b];
    end

    // Per-byte merge: on a same-address double write both ports compute the identical final word.
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (wbyte_a[i] && !(same_addr && wbyte_b[i] && (A_PRIORITY == 0)))
                new_a[8*i +: 8] = data_in_a[8*i +: 8];
            else if (same_addr && wbyte_b[i])
                new_a[8*i +: 8] = data_in_b[8*i +: 8];

            if (wbyte_b[i] && !(same_addr && wbyte_a[i] && (A_PRIORITY != 0)))
                new_b[8*i +: 8] = data_in_b[8*i +: 8];
            else if (same_addr && wbyte_a[i])
                new_b[8*i +: 8] = data_in_a[8*i +: 8];
        end
    end

    // Next-state: sweep sequencing, read-data selection, collision flag and saturating counter.
    always_comb begin
        state_d         = state_q;
        init_addr_d     = init_addr_q;
        ready_d         = ready_q;
        data_out_a_d    = data_out_a_q;
        data_out_b_d    = data_out_b_q;
        valid_a_d       = acc_a;
        valid_b_d       = acc_b;
        collision_d     = conflict;
        collision_cnt_d = collision_cnt_q;

        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + ADDR_W'(1);
            if (init_addr_q == {ADDR_W{1'b1}}) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end

        // A non-writing port sees the old word even when the other port writes the same address.
        if (acc_a)
            data_out_a_d = (wr_a && (RDW_MODE != 0)) ? new_a : old_a;
        if (acc_b)
            data_out_b_d = (wr_b && (RDW_MODE != 0)) ? new_b : old_b;

        if (conflict && (collision_cnt_q != {CNT_W{1'b1}}))
            collision_cnt_d = collision_cnt_q + CNT_W'(1);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_INIT;
            init_addr_q     <= '0;
            ready_q         <= 1'b0;
            data_out_a_q    <= '0;
            data_out_b_q    <= '0;
            valid_a_q       <= 1'b0;
            valid_b_q       <= 1'b0;
            collision_q     <= 1'b0;
            collision_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            init_addr_q     <= init_addr_d;
            ready_q         <= ready_d;
            data_out_a_q    <= data_out_a_d;
            data_out_b_q    <= data_out_b_d;
            valid_a_q       <= valid_a_d;
            valid_b_q       <= valid_b_d;
            collision_q     <= collision_d;
            collision_cnt_q <= collision_cnt_d;
        end
    end

    // Storage array: zero-fill during the sweep, otherwise merged port writes (never reset).
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr_q] <= '0;
        end else begin
            if (wr_a)
                mem[addr_a] <= new_a;
            if (wr_b)
                mem[addr_b] <= new_b;
        end
    end

    assign ready         = ready_q;
    assign data_out_a    = data_out_a_q;
    assign data_out_b    = data_out_b_q;
    assign valid_a       = valid_a_q;
    assign valid_b       = valid_b_q;
    assign collision     = collision_q;
    assign collision_cnt = collision_cnt_q;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench for dual_port_ram_be: read-first instance (u_dut0, 16-bit counter) and
// write-first instance (u_dut1, 2-bit counter) driven with identical stimulus.
module tb_dual_port_ram_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  be_a, be_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_in_a, data_in_b;

    logic        ready0, valid_a0, valid_b0, coll0;
    logic [31:0] dout_a0, dout_b0;
    logic [15:0] cnt0;
    logic        ready1, valid_a1, valid_b1, coll1;
    logic [31:0] dout_a1, dout_b1;
    logic [1:0]  cnt1;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    dual_port_ram_be #(.DATA_W(32), .ADDR_W(5), .RDW_MODE(0), .A_PRIORITY(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .ready(ready0),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(data_in_a),
        .data_out_a(dout_a0), .valid_a(valid_a0),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(data_in_b),
        .data_out_b(dout_b0), .valid_b(valid_b0),
        .collision(coll0), .collision_cnt(cnt0)
    );

    dual_port_ram_be #(.DATA_W(32), .ADDR_W(5), .RDW_MODE(1), .A_PRIORITY(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .ready(ready1),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(data_in_a),
        .data_out_a(dout_a1), .valid_a(valid_a1),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(data_in_b),
        .data_out_b(dout_b1), .valid_b(valid_b1),
        .collision(coll1), .collision_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of port activity, then land 1 time unit after the sampling edge.
    task automatic op(input logic ea, input logic wa, input logic [3:0] ba, input logic [4:0] aa,
                      input logic [31:0] da,
                      input logic eb, input logic wb, input logic [3:0] bb, input logic [4:0] ab,
                      input logic [31:0] db);
        en_a = ea; we_a = wa; be_a = ba; addr_a = aa; data_in_a = da;
        en_b = eb; we_b = wb; be_b = bb; addr_b = ab; data_in_b = db;
        step();
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
    endtask

    // Count cycles with ready low, bounded so a stuck sweep still reaches the summary.
    task automatic count_sweep(output int cycles);
        cycles = 0;
        while (ready0 !== 1'b1 && cycles < 200) begin
            cycles++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b0; we_a = 1'b0; be_a = 4'h0; addr_a = 5'd0; data_in_a = 32'h0;
        en_b = 1'b0; we_b = 1'b0; be_b = 4'h0; addr_b = 5'd0; data_in_b = 32'h0;

        // Reset state
        step();
        chk("rst_ready", {31'b0, ready0}, 32'd0);
        chk("rst_valid_a", {31'b0, valid_a0}, 32'd0);
        chk("rst_dout_a", dout_a0, 32'h0);
        chk("rst_coll", {31'b0, coll0}, 32'd0);
        chk("rst_cnt", {16'b0, cnt0}, 32'd0);
        rst = 1'b0;

        // Sweep length: exactly 32 cycles of ready=0 after release
        count_sweep(n);
        chk("sweep_len", n, 32);
        chk("sweep_ready1", {31'b0, ready1}, 32'd1);

        // Test 1: read of a swept address
        op(1, 0, 4'h0, 5'd7, 32'h0, 0, 0, 4'h0, 5'd0, 32'h0);
        chk("t1_valid_a", {31'b0, valid_a0}, 32'd1);
        chk("t1_dout_a", dout_a0, 32'h0000_0000);
        step();
        chk("t1_valid_a_drop", {31'b0, valid_a0}, 32'd0);

        // Test 2: full write then partial byte-enable write
        op(1, 1, 4'hF, 5'd0, 32'hA5A5A5A5, 0, 0, 4'h0, 5'd0, 32'h0);
        chk("t2_w1_rf", dout_a0, 32'h0000_0000);
        chk("t2_w1_wf", dout_a1, 32'hA5A5A5A5);
        op(1, 1, 4'h3, 5'd0, 32'h11223344, 0, 0, 4'h0, 5'd0, 32'h0);
        chk("t2_w2_rf", dout_a0, 32'hA5A5A5A5);
        chk("t2_w2_wf", dout_a1, 32'hA5A53344);
        op(1, 0, 4'h0, 5'd0, 32'h0, 0, 0, 4'h0, 5'd0, 32'h0);
        chk("t2_rd", dout_a0, 32'hA5A53344);

        // Test 3: same-port read-during-write
        op(1, 1, 4'hF, 5'd2, 32'h12345678, 0, 0, 4'h0, 5'd0, 32'h0);
        chk("t3_rf", dout_a0, 32'h0000_0000);
        chk("t3_wf", dout_a1, 32'h12345678);
        chk("t3_no_coll", {31'b0, coll0}, 32'd0);

        // Test 4: double write, A wins overlapping bytes
        op(1, 1, 4'hF, 5'd2, 32'h12345678, 1, 1, 4'h3, 5'd2, 32'h87654321);
        chk("t4_coll", {31'b0, coll0}, 32'd1);
        chk("t4_cnt", {16'b0, cnt0}, 32'd1);
        chk("t4_wf_b", dout_b1, 32'h12345678);
        step();
        chk("t4_coll_pulse", {31'b0, coll0}, 32'd0);
        op(1, 0, 4'h0, 5'd2, 32'h0, 0, 0, 4'h0, 5'd0, 32'h0);
        chk("t4_rd", dout_a0, 32'h12345678);

        // Test 5: disjoint byte enables on a double write
        op(1, 1, 4'hC, 5'd2, 32'h12345678, 1, 1, 4'h3, 5'd2, 32'h87654321);
        chk("t5_rf_a", dout_a0, 32'h12345678);
        chk("t5_wf_a", dout_a1, 32'h12344321);
        chk("t5_wf_b", dout_b1, 32'h12344321);
        chk("t5_cnt", {16'b0, cnt0}, 32'd2);
        op(0, 0, 4'h0, 5'd0, 32'h0, 1, 0, 4'h0, 5'd2, 32'h0);
        chk("t5_rd", dout_b0, 32'h12344321);
        chk("t5_valid_b", {31'b0, valid_b0}, 32'd1);

        // Test 6: read vs write on the same address
        op(0, 0, 4'h0, 5'd0, 32'h0, 1, 1, 4'hF, 5'd1, 32'h5A5A5A5A);
        op(1, 1, 4'hF, 5'd1, 32'hDEADBEEF, 1, 0, 4'h0, 5'd1, 32'h0);
        chk("t6_rd_old_rf", dout_b0, 32'h5A5A5A5A);
        chk("t6_rd_old_wf", dout_b1, 32'h5A5A5A5A);
        chk("t6_wr_wf", dout_a1, 32'hDEADBEEF);
        chk("t6_coll", {31'b0, coll0}, 32'd1);
        chk("t6_cnt", {16'b0, cnt0}, 32'd3);

        // Double read at the same address is not a conflict
        op(1, 0, 4'h0, 5'd1, 32'h0, 1, 0, 4'h0, 5'd1, 32'h0);
        chk("dr_coll", {31'b0, coll0}, 32'd0);
        chk("dr_data", dout_a0, 32'hDEADBEEF);
        chk("dr_cnt", {16'b0, cnt0}, 32'd3);

        // Write with no byte enables: valid pulses, memory unchanged
        op(1, 1, 4'h0, 5'd1, 32'h0, 0, 0, 4'h0, 5'd0, 32'h0);
        chk("be0_valid", {31'b0, valid_a0}, 32'd1);
        op(1, 0, 4'h0, 5'd1, 32'h0, 0, 0, 4'h0, 5'd0, 32'h0);
        chk("be0_rd", dout_a0, 32'hDEADBEEF);

        // Fourth conflict: 2-bit counter saturates at 3, 16-bit counter reaches 4
        op(1, 0, 4'h0, 5'd3, 32'h0, 1, 1, 4'hF, 5'd3, 32'h0BADF00D);
        chk("sat_cnt0", {16'b0, cnt0}, 32'd4);
        chk("sat_cnt1", {30'b0, cnt1}, 32'd3);

        // Reset mid-RUN with an access in flight: valid dropped, counters cleared
        rst = 1'b1;
        op(1, 0, 4'h0, 5'd1, 32'h0, 0, 0, 4'h0, 5'd0, 32'h0);
        chk("mrst_valid", {31'b0, valid_a0}, 32'd0);
        chk("mrst_ready", {31'b0, ready0}, 32'd0);
        rst = 1'b0;

        // Reset again 10 cycles into the sweep; accesses during INIT are ignored
        for (int i = 0; i < 9; i++) step();
        op(1, 1, 4'hF, 5'd4, 32'hFFFFFFFF, 0, 0, 4'h0, 5'd0, 32'h0);
        chk("init_ign_valid", {31'b0, valid_a0}, 32'd0);
        rst = 1'b1;
        step();
        chk("irst_cnt", {16'b0, cnt0}, 32'd0);
        chk("irst_ready", {31'b0, ready0}, 32'd0);
        rst = 1'b0;
        count_sweep(n);
        chk("resweep_len", n, 32);
        op(1, 0, 4'h0, 5'd1, 32'h0, 1, 0, 4'h0, 5'd4, 32'h0);
        chk("resweep_clear_a", dout_a0, 32'h0000_0000);
        chk("resweep_clear_b", dout_b0, 32'h0000_0000);
        chk("resweep_cnt", {16'b0, cnt0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
